// File: rtl/motor_pkg.sv
// Shared types and constants for the three-axis step planner and its
// per-axis delta calculator.
package motor_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CALC,
      PULSE,
      WAIT_BUSY,
      WAIT_DONE
   } state_t;

   localparam int STEP_W  = 16;
   localparam int DIR_BIT = STEP_W - 1;

endpackage

// File: rtl/axis_delta_calc.sv
// One axis of the move computation: clamps (target - pos) to +/-MAX_STEP
// and reports whether the clamp engaged.
module axis_delta_calc
   import motor_pkg::*;
#(
   parameter int MAX_STEP = 4000
) (
   input  logic signed [STEP_W-1:0] target,
   input  logic signed [STEP_W-1:0] pos,
   output logic signed [STEP_W-1:0] delta,
   output logic                     sat,
   output logic signed [STEP_W-1:0] next_pos
);

   localparam logic signed [STEP_W:0] LIM     = (STEP_W+1)'(MAX_STEP);
   localparam logic signed [STEP_W:0] NEG_LIM = -LIM;

   logic signed [STEP_W:0] diff;

   // One extra bit so opposite-signed endpoints cannot overflow the difference.
   always_comb begin
      diff  = {target[DIR_BIT], target} - {pos[DIR_BIT], pos};
      sat   = 1'b0;
      delta = diff[STEP_W-1:0];
      if (diff > LIM) begin
         delta = LIM[STEP_W-1:0];
         sat   = 1'b1;
      end else if (diff < NEG_LIM) begin
         delta = NEG_LIM[STEP_W-1:0];
         sat   = 1'b1;
      end
      next_pos = pos + delta;
   end

endmodule

// File: rtl/step_command_planner.sv
// Three-axis step command planner: turns absolute targets into saturated
// per-move deltas and handshakes each move with the motor driver.
// Optional soft position limits: define STEP_PLANNER_SOFT_LIMIT_EN.
module step_command_planner
   import motor_pkg::*;
#(
   parameter int MAX_STEP     = 4000,
   parameter int PULSE_CYCLES = 4,
   parameter int BUSY_TIMEOUT = 1024,
   parameter int POS_MIN      = -20000,
   parameter int POS_MAX      = 20000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              target_valid,
   input  logic [STEP_W-1:0] m1_target,
   input  logic [STEP_W-1:0] m2_target,
   input  logic [STEP_W-1:0] m3_target,
   input  logic              zero_pos,
   input  logic              driver_ready,
   output logic [STEP_W-1:0] m1_steps,
   output logic [STEP_W-1:0] m2_steps,
   output logic [STEP_W-1:0] m3_steps,
   output logic              drive_signal_out,
   output logic [STEP_W-1:0] m1_pos,
   output logic [STEP_W-1:0] m2_pos,
   output logic [STEP_W-1:0] m3_pos,
   output logic              busy,
   output logic              target_dropped,
   output logic              fault
);

   localparam int NUM_AXES = 3;
   localparam int CNT_W    = $clog2(BUSY_TIMEOUT + PULSE_CYCLES) + 2;

   if (MAX_STEP < 1 || MAX_STEP > 16383 || POS_MIN > POS_MAX) begin : g_param_err
      $error("step_command_planner: bad MAX_STEP or position limits");
   end

   state_t                            state, state_nxt;
   logic                              rdy_meta, rdy_s;
   logic                              pending, any_move, any_sat, timeout;
   logic [CNT_W-1:0]                  cnt;
   logic [NUM_AXES-1:0][STEP_W-1:0]   tgt_in, tgt_cap, hold, pos, steps, delta, pos_nxt;
   logic [NUM_AXES-1:0]               sat;

   assign tgt_in = {m3_target, m2_target, m1_target};

`ifdef STEP_PLANNER_SOFT_LIMIT_EN
   always_comb begin
      tgt_cap = tgt_in;
      for (int i = 0; i < NUM_AXES; i++) begin
         if ($signed(tgt_in[i]) < POS_MIN)
            tgt_cap[i] = STEP_W'(POS_MIN);
         else if ($signed(tgt_in[i]) > POS_MAX)
            tgt_cap[i] = STEP_W'(POS_MAX);
      end
   end
`else
   assign tgt_cap = tgt_in;
`endif

   for (genvar i = 0; i < NUM_AXES; i++) begin : g_axis
      axis_delta_calc #(.MAX_STEP(MAX_STEP)) u_calc (
         .target   (hold[i]),
         .pos      (pos[i]),
         .delta    (delta[i]),
         .sat      (sat[i]),
         .next_pos (pos_nxt[i])
      );
   end

   always_comb begin
      state_nxt = state;
      any_move  = |delta;
      any_sat   = |sat;
      timeout   = (state == WAIT_BUSY) && rdy_s && (cnt == CNT_W'(BUSY_TIMEOUT - 1));
      case (state)
         // A target arriving this cycle lands in hold at the same edge, so CALC sees it.
         IDLE:      if (!zero_pos && (pending || target_valid) && rdy_s) state_nxt = CALC;
         CALC:      state_nxt = any_move ? PULSE : IDLE;
         PULSE:     if (cnt == CNT_W'(PULSE_CYCLES - 1)) state_nxt = WAIT_BUSY;
         WAIT_BUSY: if (!rdy_s) state_nxt = WAIT_DONE;
                    else if (timeout) state_nxt = IDLE;
         WAIT_DONE: if (rdy_s) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= IDLE;
         rdy_meta       <= 1'b0;
         rdy_s          <= 1'b0;
         pending        <= 1'b0;
         cnt            <= '0;
         hold           <= '0;
         pos            <= '0;
         steps          <= '0;
         target_dropped <= 1'b0;
         fault          <= 1'b0;
      end else begin
         state          <= state_nxt;
         rdy_meta       <= driver_ready;
         rdy_s          <= rdy_meta;
         cnt            <= (state_nxt != state) ? '0 : cnt + 1'b1;
         target_dropped <= target_valid && pending && (state != CALC);
         if (target_valid)
            hold <= tgt_cap;
         // Saturated moves keep the target pending so the remainder follows.
         if (target_valid)
            pending <= 1'b1;
         else if (state == CALC)
            pending <= any_sat;
         if (state == IDLE && zero_pos)
            pos <= '0;
         if (state == CALC) begin
            steps <= delta;
            pos   <= pos_nxt;
         end
         if (timeout)
            fault <= 1'b1;
      end
   end

   assign {m3_steps, m2_steps, m1_steps} = steps;
   assign {m3_pos, m2_pos, m1_pos}       = pos;
   assign drive_signal_out               = (state == PULSE);
   assign busy                           = (state != IDLE);

endmodule

// File: tb/tb_step_command_planner.sv
// Randomized and directed checks of step_command_planner against a
// move-level reference model with a behavioural driver handshake.
module tb_step_command_planner;

   localparam int MAX_STEP     = 4000;
   localparam int PULSE_CYCLES = 4;
   localparam int BUSY_TIMEOUT = 1024;
   localparam int POS_MIN      = -20000;
   localparam int POS_MAX      = 20000;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        target_valid = 1'b0;
   logic        zero_pos = 1'b0;
   logic        driver_ready = 1'b1;
   logic [15:0] m1_target = '0, m2_target = '0, m3_target = '0;
   logic [15:0] m1_steps, m2_steps, m3_steps, m1_pos, m2_pos, m3_pos;
   logic        drive_signal_out, busy, target_dropped, fault;

   int n_tests = 0;
   int n_fail  = 0;
   int mpos[3];
   int mtgt[3];
   int first_rise;
   bit drv_auto = 1'b1;

   step_command_planner #(
      .MAX_STEP(MAX_STEP), .PULSE_CYCLES(PULSE_CYCLES), .BUSY_TIMEOUT(BUSY_TIMEOUT),
      .POS_MIN(POS_MIN), .POS_MAX(POS_MAX)
   ) dut (
      .clock(clock), .reset(reset), .target_valid(target_valid),
      .m1_target(m1_target), .m2_target(m2_target), .m3_target(m3_target),
      .zero_pos(zero_pos), .driver_ready(driver_ready),
      .m1_steps(m1_steps), .m2_steps(m2_steps), .m3_steps(m3_steps),
      .drive_signal_out(drive_signal_out),
      .m1_pos(m1_pos), .m2_pos(m2_pos), .m3_pos(m3_pos),
      .busy(busy), .target_dropped(target_dropped), .fault(fault)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int clampi(input int v, input int lo, input int hi);
      return (v < lo) ? lo : (v > hi) ? hi : v;
   endfunction

   function automatic int tgt_eff(input int t);
`ifdef STEP_PLANNER_SOFT_LIMIT_EN
      return clampi(t, POS_MIN, POS_MAX);
`else
      return t;
`endif
   endfunction

   function automatic int steps_of(input int i);
      case (i)
         0:       return int'($signed(m1_steps));
         1:       return int'($signed(m2_steps));
         default: return int'($signed(m3_steps));
      endcase
   endfunction

   function automatic int pos_of(input int i);
      case (i)
         0:       return int'($signed(m1_pos));
         1:       return int'($signed(m2_pos));
         default: return int'($signed(m3_pos));
      endcase
   endfunction

   // Behavioural driver: some time after a strobe it goes not-ready, then ready again.
   initial forever begin
      @(posedge drive_signal_out);
      if (drv_auto) begin
         repeat ($urandom_range(1, 6)) @(negedge clock);
         driver_ready = 1'b0;
         repeat ($urandom_range(8, 12)) @(negedge clock);
         driver_ready = 1'b1;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Applies a target for one cycle; returns at the negedge after it was sampled.
   task automatic issue(input int a, input int b, input int c);
      @(negedge clock);
      m1_target = 16'(a); m2_target = 16'(b); m3_target = 16'(c);
      target_valid = 1'b1;
      mtgt[0] = tgt_eff(a); mtgt[1] = tgt_eff(b); mtgt[2] = tgt_eff(c);
      @(negedge clock);
      target_valid = 1'b0;
   endtask

   task automatic do_zero();
      @(negedge clock); zero_pos = 1'b1;
      @(negedge clock); zero_pos = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("zero_pos", pos_of(i), 0);
         mpos[i] = 0;
      end
   endtask

   // Follows a move to completion, checking each strobe against the model.
   task automatic run_until_idle(input string tag, input int budget);
      int quiet = 0, cyc = 0, strobes = 0, width = 0, maxd = 0, d;
      logic prev = 1'b0;
      first_rise = -1;
      for (int i = 0; i < 3; i++) begin
         d = (mtgt[i] > mpos[i]) ? mtgt[i] - mpos[i] : mpos[i] - mtgt[i];
         if (d > maxd) maxd = d;
      end
      while (quiet < 6 && cyc < budget) begin
         @(negedge clock);
         cyc++;
         if (drive_signal_out && !prev) begin
            if (first_rise < 0) first_rise = cyc;
            strobes++;
            width = 1;
            for (int i = 0; i < 3; i++) begin
               d = clampi(mtgt[i] - mpos[i], -MAX_STEP, MAX_STEP);
               check({tag, "_steps"}, steps_of(i), d);
               mpos[i] += d;
            end
         end else if (drive_signal_out) width++;
         if (!drive_signal_out && prev) check({tag, "_width"}, width, PULSE_CYCLES);
         quiet = (busy || drive_signal_out) ? 0 : quiet + 1;
         prev  = drive_signal_out;
      end
      check({tag, "_settled"}, int'(quiet >= 6), 1);
      check({tag, "_nstrobe"}, strobes, (maxd + MAX_STEP - 1) / MAX_STEP);
      for (int i = 0; i < 3; i++) begin
         check({tag, "_pos"}, pos_of(i), mpos[i]);
         check({tag, "_conv"}, mpos[i], mtgt[i]);
      end
   endtask

   initial begin
      int a, b, c, drops, rises, waited;
      for (int i = 0; i < 3; i++) begin mpos[i] = 0; mtgt[i] = 0; end
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("rst_steps", int'(m1_steps | m2_steps | m3_steps), 0);
      check("rst_pos", int'(m1_pos | m2_pos | m3_pos), 0);
      check("rst_drive", int'(drive_signal_out), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_dropped", int'(target_dropped), 0);
      check("rst_fault", int'(fault), 0);
      repeat (4) @(negedge clock);

      // Basic move plus CALC/strobe latency.
      issue(100, -50, 0);
      check("lat_busy", int'(busy), 1);
      check("lat_drive_c1", int'(drive_signal_out), 0);
      run_until_idle("basic", 200);
      check("lat_rise", first_rise, 1);
      check("basic_m1_steps_hex", int'(m1_steps), 16'h0064);
      check("basic_m2_steps_hex", int'(m2_steps), 16'hFFCE);

      // Saturating move split across three handshakes.
      do_zero();
      issue(10000, 0, 0);
      run_until_idle("sat", 1000);

      // No-motion target.
      issue(mpos[0], mpos[1], mpos[2]);
      run_until_idle("equal", 100);

      // Large target: soft limit clamps it when enabled.
      issue(30000, 0, 0);
      run_until_idle("big", 2000);
      do_zero();

      // Randomized targets, occasionally repeating the current position.
      for (int k = 0; k < 16; k++) begin
         if (k % 5 == 4) issue(mpos[0], mpos[1], mpos[2]);
         else issue(int'($urandom_range(0, 24000)) - 12000,
                    int'($urandom_range(0, 24000)) - 12000,
                    int'($urandom_range(0, 24000)) - 12000);
         run_until_idle("rand", 2000);
      end

      // Two targets while the driver is busy: one drop, latest target issued.
      do_zero();
      drv_auto = 1'b0;
      issue(50, 50, 50);
      waited = 0;
      while (!drive_signal_out && waited < 20) begin @(negedge clock); waited++; end
      check("drop_a_rise", int'(drive_signal_out), 1);
      for (int i = 0; i < 3; i++) begin
         check("drop_a_steps", steps_of(i), 50);
         mpos[i] = 50;
      end
      waited = 0;
      while (drive_signal_out && waited < 20) begin @(negedge clock); waited++; end
      driver_ready = 1'b0;
      repeat (5) @(negedge clock);
      drops = 0;
      m1_target = 16'd0; m2_target = 16'd0; m3_target = 16'd0;
      target_valid = 1'b1;
      @(negedge clock); drops += int'(target_dropped);
      a = -30; b = 70; c = 50;
      m1_target = 16'(a); m2_target = 16'(b); m3_target = 16'(c);
      mtgt[0] = a; mtgt[1] = b; mtgt[2] = c;
      @(negedge clock); drops += int'(target_dropped);
      target_valid = 1'b0;
      repeat (3) begin @(negedge clock); drops += int'(target_dropped); end
      check("drop_count", drops, 1);
      drv_auto = 1'b1;
      driver_ready = 1'b1;
      run_until_idle("drop_b", 300);

      // Reset in the middle of a strobe.
      issue(mpos[0] + 300, mpos[1], mpos[2]);
      waited = 0;
      while (!drive_signal_out && waited < 20) begin @(negedge clock); waited++; end
      check("rstmid_rise", int'(drive_signal_out), 1);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("rstmid_drive", int'(drive_signal_out), 0);
      check("rstmid_busy", int'(busy), 0);
      check("rstmid_pos", int'(m1_pos | m2_pos | m3_pos), 0);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin mpos[i] = 0; mtgt[i] = 0; end
      rises = 0;
      repeat (25) begin @(negedge clock); rises += int'(drive_signal_out | busy); end
      check("rstmid_no_pending", rises, 0);

      // Driver never drops ready: busy timeout sets a sticky fault.
      drv_auto = 1'b0;
      driver_ready = 1'b1;
      issue(500, 0, 0);
      waited = 0;
      while (!drive_signal_out && waited < 20) begin @(negedge clock); waited++; end
      check("to_steps", steps_of(0), 500);
      mpos[0] = 500;
      waited = 0;
      while (drive_signal_out && waited < 20) begin @(negedge clock); waited++; end
      repeat (BUSY_TIMEOUT - 1) @(negedge clock);
      check("to_fault_early", int'(fault), 0);
      check("to_busy_early", int'(busy), 1);
      @(negedge clock);
      check("to_fault", int'(fault), 1);
      check("to_busy", int'(busy), 0);
      check("to_pos", pos_of(0), 500);
      repeat (5) @(negedge clock);
      check("to_fault_sticky", int'(fault), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/step_command_planner.md
Name: step_command_planner

Overview:
- Upstream stage of the three-axis motor driver.
- Accepts absolute target positions (signed steps) from the PID/kinematics stage and tracks each motor's commanded position.
- Computes the per-move signed delta, saturates it, and presents it as 16-bit step commands (bit 15 = direction, two's complement).
- Pulses the drive strobe only when the driver reports ready, then tracks the driver's busy/ready cycle before issuing the next move.

Parameters:
- MAX_STEP, 4000: largest delta magnitude per move; must be ≤16383 because the driver doubles the magnitude into 15 bits.
- PULSE_CYCLES, 4: clock cycles drive_signal_out is held high.
- BUSY_TIMEOUT, 1024: cycles to wait for driver ready to drop after the strobe before declaring a fault.
- POS_MIN, -20000: soft lower limit (optional feature only).
- POS_MAX, 20000: soft upper limit (optional feature only).

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- target_valid  in  1  one-cycle strobe; m1..m3_target are valid.
- m1_target  in  16  signed absolute target, motor 1 (m2_target, m3_target identical).
- zero_pos  in  1  set all tracked positions to 0; honoured in IDLE only.
- driver_ready  in  1  driver ready, asynchronous to clock.
- m1_steps  out  16  signed delta command, motor 1 (m2_steps, m3_steps identical).
- drive_signal_out  out  1  drive strobe to the driver.
- m1_pos  out  16  tracked commanded position (m2_pos, m3_pos identical).
- busy  out  1  high in any state other than IDLE.
- target_dropped  out  1  one-cycle pulse when a pending target is overwritten.
- fault  out  1  sticky busy-timeout flag; cleared only by reset.

Behaviour:
- Reset values: all steps outputs, positions, drive_signal_out, busy, target_dropped and fault are 0. State is IDLE. The pending flag is clear.
- driver_ready passes through a two-flop synchronizer; rdy_s is the synchronized value.
- Target capture (any state): when target_valid is high, the targets are latched into a one-entry holding register and pending is set.
  - target_dropped pulses if pending was already set and is not being consumed in that same cycle.
  - Latest target wins.
- IDLE:
  - zero_pos has priority: positions are set to 0 and the state stays IDLE.
  - Otherwise, if pending and rdy_s, go to CALC.
- CALC (1 cycle), per motor:
  - diff = target - pos, computed in 17 bits signed.
  - delta = diff clamped to [-MAX_STEP, +MAX_STEP].
  - steps output <= delta (16-bit); pos <= pos + delta.
  - Pending is cleared unless any motor saturated; on saturation pending stays set so the remainder issues on the next move.
  - A target_valid in this cycle re-sets pending with the new target.
  - If all deltas are 0, go to IDLE with no strobe. Otherwise go to PULSE.
- PULSE: drive_signal_out is high for exactly PULSE_CYCLES cycles, then WAIT_BUSY. The steps outputs stay stable from CALC until the next CALC.
- WAIT_BUSY:
  - If rdy_s is 0, go to WAIT_DONE.
  - If BUSY_TIMEOUT cycles elapse first, set fault and go to IDLE.
- WAIT_DONE: when rdy_s is 1, go to IDLE.
- Latency: target_valid in IDLE with rdy_s high gives CALC at +1 and drive_signal_out rising at +2.
- zero_pos outside IDLE is ignored; it is not queued.
- Reset mid-move drops drive_signal_out immediately and clears the pending target.

Optional Feature:
- Macro: STEP_PLANNER_SOFT_LIMIT_EN.
- Defined: each target is clamped to [POS_MIN, POS_MAX] when captured, so tracked positions never leave that range.
- Undefined: targets are used unclamped, and POS_MIN/POS_MAX are unused.

Decomposition:
- Shared package (motor_pkg):
  - state enum: IDLE, CALC, PULSE, WAIT_BUSY, WAIT_DONE
  - step word width of 16
  - helper constant for the direction-bit index (15)
- Sub-module axis_delta_calc, instantiated three times:
  - inputs: target, pos
  - outputs: clamped delta, saturated flag, next pos

Test Plan:
- Targets (100, -50, 0) from zero with driver_ready high → steps 0x0064/0xFFCE/0x0000, one 4-cycle strobe, pos = (100, -50, 0).
- Target m1 = 10000 with MAX_STEP 4000 → three moves of 4000, 4000, 2000, each gated by a driver ready low→high cycle; final m1_pos = 10000.
- Target equal to current position → no strobe, busy returns low after CALC.
- Two target_valid pulses while in WAIT_DONE → target_dropped pulses once; the second target is issued.
- driver_ready held high forever after the strobe → fault set after 1024 cycles, state IDLE.
- With STEP_PLANNER_SOFT_LIMIT_EN, target 30000 → m1_pos converges to 20000; zero_pos in IDLE → all pos = 0.
